// File: rtl/wwm_pkg.sv
// Shared definitions for the World War Math turn controller: one-hot state
// codes, default screen geometry and a generic sign-extension helper.
package wwm_pkg;

    localparam int unsigned ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam int unsigned ST_I_B      = 0;
    localparam int unsigned ST_AIM_B    = 1;
    localparam int unsigned ST_FLIGHT_B = 2;
    localparam int unsigned ST_DONE_B   = 3;

    localparam state_t ST_I      = 4'b0001;
    localparam state_t ST_AIM    = 4'b0010;
    localparam state_t ST_FLIGHT = 4'b0100;
    localparam state_t ST_DONE   = 4'b1000;

    localparam int unsigned COORD_W_DEF = 10;
    localparam int unsigned VEL_W_DEF   = 4;
    localparam int unsigned X_MIN_DEF   = 160;
    localparam int unsigned X_MAX_DEF   = 775;
    localparam int unsigned Y_MIN_DEF   = 50;
    localparam int unsigned Y_MAX_DEF   = 475;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
        sext = $signed(v << (32 - w)) >>> (32 - w);
    endfunction

endpackage

// File: rtl/wwm_proj_step.sv
// Combinational projectile step: next position, target hit, playfield exit
// and the next position clamped to the playfield.
module wwm_proj_step
    import wwm_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned VEL_W   = VEL_W_DEF,
    parameter int unsigned X_MIN   = X_MIN_DEF,
    parameter int unsigned X_MAX   = X_MAX_DEF,
    parameter int unsigned Y_MIN   = Y_MIN_DEF,
    parameter int unsigned Y_MAX   = Y_MAX_DEF
) (
    input  logic [COORD_W-1:0]        proj_x,
    input  logic [COORD_W-1:0]        proj_y,
    input  logic [VEL_W-1:0]          vx,
    input  logic [VEL_W-1:0]          vy,
    input  logic [COORD_W-1:0]        tgt_x_lo,
    input  logic [COORD_W-1:0]        tgt_x_hi,
    input  logic [COORD_W-1:0]        tgt_y_lo,
    input  logic [COORD_W-1:0]        tgt_y_hi,
    output logic signed [COORD_W+1:0] nx_c,
    output logic signed [COORD_W+1:0] ny_c,
    output logic                      hit_c,
    output logic                      oob_c,
    output logic [COORD_W-1:0]        clamp_x_c,
    output logic [COORD_W-1:0]        clamp_y_c
);

    // Two guard bits keep the step free of wraparound in either direction.
    localparam int unsigned SW = COORD_W + 2;

    localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMIN_S = SW'(Y_MIN);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

    logic signed [SW-1:0] px_s, py_s, vx_s, vy_s;
    logic signed [SW-1:0] xlo_s, xhi_s, ylo_s, yhi_s;
    logic                 x_lo_out, x_hi_out, y_lo_out, y_hi_out;

    always_comb begin
        px_s  = $signed({2'b00, proj_x});
        py_s  = $signed({2'b00, proj_y});
        vx_s  = SW'(sext(32'(vx), VEL_W));
        vy_s  = SW'(sext(32'(vy), VEL_W));
        xlo_s = $signed({2'b00, tgt_x_lo});
        xhi_s = $signed({2'b00, tgt_x_hi});
        ylo_s = $signed({2'b00, tgt_y_lo});
        yhi_s = $signed({2'b00, tgt_y_hi});

        // Screen y grows downward, so positive vy moves the shot up.
        nx_c = px_s + vx_s;
        ny_c = py_s - vy_s;

        hit_c = (nx_c >= xlo_s) && (nx_c <= xhi_s) && (ny_c >= ylo_s) && (ny_c <= yhi_s);

        x_lo_out = nx_c < XMIN_S;
        x_hi_out = nx_c > XMAX_S;
        y_lo_out = ny_c < YMIN_S;
        y_hi_out = ny_c > YMAX_S;
        oob_c    = x_lo_out || x_hi_out || y_lo_out || y_hi_out;

        clamp_x_c = x_lo_out ? COORD_W'(X_MIN) : x_hi_out ? COORD_W'(X_MAX) : COORD_W'(nx_c);
        clamp_y_c = y_lo_out ? COORD_W'(Y_MIN) : y_hi_out ? COORD_W'(Y_MAX) : COORD_W'(ny_c);
    end

endmodule

// File: rtl/wwm_turn_ctrl.sv
// World War Math turn controller: game FSM, projectile flight, scoring and
// turn rotation. Define WWM_GRAVITY_EN to add periodic vy decay in flight.
module wwm_turn_ctrl
    import wwm_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = COORD_W_DEF,
    parameter int unsigned VEL_W       = VEL_W_DEF,
    parameter int unsigned X_MIN       = X_MIN_DEF,
    parameter int unsigned X_MAX       = X_MAX_DEF,
    parameter int unsigned Y_MIN       = Y_MIN_DEF,
    parameter int unsigned Y_MAX       = Y_MAX_DEF,
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned T_W         = 16,
    parameter int unsigned T_MAX       = 1000,
    parameter int unsigned GRAV_PERIOD = 4,
    localparam int unsigned PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic                           Ack,
    input  logic                           Fire,
    input  logic                           tick,
    input  logic [VEL_W-1:0]               vx_in,
    input  logic [VEL_W-1:0]               vy_in,
    input  logic [NUM_PLAYERS*COORD_W-1:0] x_init,
    input  logic [NUM_PLAYERS*COORD_W-1:0] y_init,
    input  logic [NUM_PLAYERS*COORD_W-1:0] tgt_x_lo,
    input  logic [NUM_PLAYERS*COORD_W-1:0] tgt_x_hi,
    input  logic [NUM_PLAYERS*COORD_W-1:0] tgt_y_lo,
    input  logic [NUM_PLAYERS*COORD_W-1:0] tgt_y_hi,
    output logic [COORD_W-1:0]             proj_x,
    output logic [COORD_W-1:0]             proj_y,
    output logic [VEL_W-1:0]               vx,
    output logic [VEL_W-1:0]               vy,
    output logic [PW-1:0]                  player,
    output logic [NUM_PLAYERS*8-1:0]       scores,
    output logic [PW-1:0]                  winner,
    output logic                           q_I,
    output logic                           q_Aim,
    output logic                           q_Flight,
    output logic                           q_Done,
    output logic                           hit_pulse,
    output logic                           miss_pulse,
    output logic [T_W-1:0]                 t_air
);

    state_t                     state_q, state_d;
    logic [COORD_W-1:0]         proj_x_q, proj_x_d, proj_y_q, proj_y_d;
    logic [VEL_W-1:0]           vx_q, vx_d, vy_q, vy_d;
    logic [PW-1:0]              player_q, player_d, winner_q, winner_d;
    logic [NUM_PLAYERS*8-1:0]   scores_q, scores_d;
    logic [T_W-1:0]             t_air_q, t_air_d;
    logic                       hit_q, hit_d, miss_q, miss_d;

    logic [COORD_W-1:0]         sel_x_init, sel_y_init;
    logic [COORD_W-1:0]         sel_x_lo, sel_x_hi, sel_y_lo, sel_y_hi;
    logic [7:0]                 cur_score, new_score;
    logic [PW-1:0]              player_nxt;
    logic [T_W-1:0]             t_air_inc;
    logic                       timeout, win, resolve;

    logic signed [COORD_W+1:0]  step_nx, step_ny;
    logic                       step_hit, step_oob;
    logic [COORD_W-1:0]         step_cx, step_cy;

`ifdef WWM_GRAVITY_EN
    localparam int unsigned GW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
    localparam logic [VEL_W-1:0] VY_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    logic [GW-1:0] grav_cnt_q, grav_cnt_d;
`endif

    // Per-player views of the packed launch points, targets and score.
    always_comb begin
        sel_x_init = '0;
        sel_y_init = '0;
        sel_x_lo   = '0;
        sel_x_hi   = '0;
        sel_y_lo   = '0;
        sel_y_hi   = '0;
        cur_score  = '0;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            if (player_q == PW'(p)) begin
                sel_x_init = x_init[p*COORD_W +: COORD_W];
                sel_y_init = y_init[p*COORD_W +: COORD_W];
                sel_x_lo   = tgt_x_lo[p*COORD_W +: COORD_W];
                sel_x_hi   = tgt_x_hi[p*COORD_W +: COORD_W];
                sel_y_lo   = tgt_y_lo[p*COORD_W +: COORD_W];
                sel_y_hi   = tgt_y_hi[p*COORD_W +: COORD_W];
                cur_score  = scores_q[p*8 +: 8];
            end
        end
        new_score  = cur_score + 8'd1;
        win        = new_score == 8'(WIN_SCORE);
        player_nxt = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
        t_air_inc  = t_air_q + T_W'(1);
        timeout    = t_air_inc >= T_W'(T_MAX);
        resolve    = step_hit || step_oob || timeout;
    end

    wwm_proj_step #(
        .COORD_W (COORD_W),
        .VEL_W   (VEL_W),
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX)
    ) u_step (
        .proj_x    (proj_x_q),
        .proj_y    (proj_y_q),
        .vx        (vx_q),
        .vy        (vy_q),
        .tgt_x_lo  (sel_x_lo),
        .tgt_x_hi  (sel_x_hi),
        .tgt_y_lo  (sel_y_lo),
        .tgt_y_hi  (sel_y_hi),
        .nx_c      (step_nx),
        .ny_c      (step_ny),
        .hit_c     (step_hit),
        .oob_c     (step_oob),
        .clamp_x_c (step_cx),
        .clamp_y_c (step_cy)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_I;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a hit outranks bounds and timeout on the same step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_I:      if (Start) state_d = ST_AIM;
            ST_AIM:    if (Fire)  state_d = ST_FLIGHT;
            ST_FLIGHT: begin
                if (tick) begin
                    if (step_hit) begin
                        state_d = win ? ST_DONE : ST_AIM;
                    end else if (step_oob || timeout) begin
                        state_d = ST_AIM;
                    end
                end
            end
            ST_DONE:   if (Ack) state_d = ST_I;
            default:   state_d = ST_I;
        endcase
    end

    // Datapath next values for each state.
    always_comb begin
        proj_x_d = proj_x_q;
        proj_y_d = proj_y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        player_d = player_q;
        winner_d = winner_q;
        scores_d = scores_q;
        t_air_d  = t_air_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
`ifdef WWM_GRAVITY_EN
        grav_cnt_d = grav_cnt_q;
`endif
        case (state_q)
            ST_I: begin
                if (Start) begin
                    scores_d = '0;
                    player_d = '0;
                    winner_d = '0;
                end
            end
            ST_AIM: begin
                proj_x_d = sel_x_init;
                proj_y_d = sel_y_init;
                t_air_d  = '0;
`ifdef WWM_GRAVITY_EN
                grav_cnt_d = '0;
`endif
                if (Fire) begin
                    vx_d = vx_in;
                    vy_d = vy_in;
                end
            end
            ST_FLIGHT: begin
                if (tick) begin
                    t_air_d  = t_air_inc;
                    proj_x_d = resolve ? step_cx : COORD_W'(step_nx);
                    proj_y_d = resolve ? step_cy : COORD_W'(step_ny);
                    if (step_hit) begin
                        hit_d = 1'b1;
                        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                            if (player_q == PW'(p)) scores_d[p*8 +: 8] = new_score;
                        end
                        if (win) winner_d = player_q;
                        else     player_d = player_nxt;
                    end else if (step_oob || timeout) begin
                        miss_d   = 1'b1;
                        player_d = player_nxt;
                    end
`ifdef WWM_GRAVITY_EN
                    // Decay lands after this tick's position step.
                    if (grav_cnt_q == GW'(GRAV_PERIOD - 1)) begin
                        grav_cnt_d = '0;
                        if (vy_q != VY_MIN) vy_d = vy_q - VEL_W'(1);
                    end else begin
                        grav_cnt_d = grav_cnt_q + GW'(1);
                    end
`else
                    vy_d = vy_q;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            proj_x_q <= '0;
            proj_y_q <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            player_q <= '0;
            winner_q <= '0;
            scores_q <= '0;
            t_air_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            proj_x_q <= proj_x_d;
            proj_y_q <= proj_y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            player_q <= player_d;
            winner_q <= winner_d;
            scores_q <= scores_d;
            t_air_q  <= t_air_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

`ifdef WWM_GRAVITY_EN
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            grav_cnt_q <= '0;
        end else begin
            grav_cnt_q <= grav_cnt_d;
        end
    end
`endif

    assign proj_x     = proj_x_q;
    assign proj_y     = proj_y_q;
    assign vx         = vx_q;
    assign vy         = vy_q;
    assign player     = player_q;
    assign scores     = scores_q;
    assign winner     = winner_q;
    assign t_air      = t_air_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign q_I        = state_q[ST_I_B];
    assign q_Aim      = state_q[ST_AIM_B];
    assign q_Flight   = state_q[ST_FLIGHT_B];
    assign q_Done     = state_q[ST_DONE_B];

endmodule

// File: doc/wwm_turn_ctrl.md
# wwm_turn_ctrl

Parametrised multi-player turn controller for World War Math. It sequences game start, per-player aiming, projectile flight, hit/miss resolution, scoring and game-over. It integrates projectile motion on a frame tick, with optional gravity, and rotates turns among `NUM_PLAYERS`. It sits between the keypad/button debouncers (Start/Ack/Fire, velocity entry) and the VGA renderer, which draws `proj_x`/`proj_y`.

## Interface
Parameters:
- `NUM_PLAYERS`, 2 — players in rotation (2..8); `PW = $clog2(NUM_PLAYERS)`, min 1.
- `COORD_W`, 10 — coordinate width, unsigned screen pixels, y grows downward.
- `VEL_W`, 4 — signed two's-complement velocity width.
- `X_MIN`/`X_MAX`, 160/775 — inclusive playfield x bounds.
- `Y_MIN`/`Y_MAX`, 50/475 — inclusive playfield y bounds.
- `WIN_SCORE`, 3 — hits needed to win.
- `T_W`, 16 — `t_air` width.
- `T_MAX`, 1000 — flight timeout in ticks.
- `GRAV_PERIOD`, 4 — ticks per gravity decrement (used only with the gravity macro).

Ports:
- `clk` in 1 — clock.
- `Reset` in 1 — asynchronous, active-high.
- `Start`, `Ack`, `Fire` in 1 each — level-sampled every clk.
- `tick` in 1 — one-cycle frame step enable.
- `vx_in`, `vy_in` in VEL_W — signed launch velocity; `vy` positive means up.
- `x_init`, `y_init` in NUM_PLAYERS*COORD_W — packed launch points; player p occupies `[p*COORD_W +: COORD_W]`.
- `tgt_x_lo`, `tgt_x_hi`, `tgt_y_lo`, `tgt_y_hi` in NUM_PLAYERS*COORD_W — packed inclusive target box for player p's shot.
- `proj_x`, `proj_y` out COORD_W — projectile position.
- `vx`, `vy` out VEL_W — current flight velocity.
- `player` out PW — current shooter.
- `scores` out NUM_PLAYERS*8 — packed per-player hit counts.
- `winner` out PW — valid in DONE.
- `q_I`, `q_Aim`, `q_Flight`, `q_Done` out 1 each — one-hot state.
- `hit_pulse`, `miss_pulse` out 1 each — one-cycle flight result.
- `t_air` out T_W — ticks since launch.

## Operation
- **States:** I, AIM, FLIGHT, DONE, one-hot encoded.
- **I:**
  - Start → AIM.
  - On the same edge: `scores` cleared, `player` set to 0.
- **AIM:**
  - Every cycle: `proj` loads the current player's `x_init`/`y_init`, `t_air` is set to 0.
  - Fire → FLIGHT; `vx`/`vy` latch `vx_in`/`vy_in` on that edge.
- **FLIGHT step:** on each `tick`:
  - `nx = proj_x + sext(vx)`, `ny = proj_y - sext(vy)`, computed signed at COORD_W+2 bits, so there is no wraparound.
  - `t_air` increments.
- **Resolution, priority order, evaluated on the step's next position:**
  - Hit: `nx`,`ny` inside the current player's target box. Score for the current player increments. If the new score equals WIN_SCORE → DONE with `winner = player`; else → AIM.
  - Miss: `nx` < X_MIN, `nx` > X_MAX, `ny` < Y_MIN or `ny` > Y_MAX, or `t_air` reaches T_MAX. → AIM.
  - On both hit and miss, `proj` takes `(nx, ny)` clamped to the playfield.
- **Turn rotation:** on leaving FLIGHT to AIM, `player = (player == NUM_PLAYERS-1) ? 0 : player+1`.
- **Ignored inputs:** Fire outside AIM; Start outside I; Ack outside DONE; `tick` outside FLIGHT.
- **DONE:** Ack → I. Scores and winner are held until the next Start.

## Timing
- **Reset values:** state I (`q_I`=1, other state bits 0); `proj_x`, `proj_y`, `vx`, `vy`, `player`, `scores`, `winner`, `t_air` and both pulses all 0.
- **Reset mid-operation:** immediate return to these values; no flight or score survives.
- **Latencies:**
  - Start/Fire/Ack → state change on the next clk edge, one cycle.
  - `tick` → updated position, `t_air` and resolution state on the same edge.
- **Result pulses:** `hit_pulse`/`miss_pulse` are registered and high for exactly the cycle after the resolving edge, i.e. coincident with the new state.
- **Simultaneous events:** a hit has priority over out-of-bounds and timeout on the same step.

## Configuration
- **`WWM_GRAVITY_EN` defined:**
  - A counter of FLIGHT ticks wraps at GRAV_PERIOD.
  - On wrap, `vy` decrements by 1, saturating at the signed minimum.
  - The decrement is applied after the position step of that tick.
  - The counter clears in AIM.
- **Undefined:** `vy` is constant through flight (straight-line trajectory). The counter is not instantiated.

## Structure
- **Package `wwm_pkg`:**
  - State one-hot localparams.
  - Default screen bounds.
  - Default COORD_W/VEL_W.
  - A `sext` helper function.
- **Sub-module `wwm_proj_step`:** combinational. Inputs: position, velocity, target box, bounds. Outputs: `nx`/`ny`, hit, out-of-bounds, clamped position.
- **Parent:** holds the FSM, counters and scores.

## Test plan
All scenarios use default parameters.
- **Miss, x bound:** P0 `x_init`=200, `y_init`=400, `vx`=3, `vy`=0, gravity off. Miss on tick 192 (`nx`=776); `proj_x`=775, `player`=1, `miss_pulse` for 1 cycle.
- **Hit:** P0 `x_init`=200, `y_init`=470, target 650..675 × 470..475, `vx`=5, `vy`=0. Hit on tick 90 (`nx`=650); `scores[0]`=1, state AIM, `player`=1.
- **Timeout:** `vx`=`vy`=0. Miss at `t_air`=1000; `player` advances.
- **Win:** three P0 hits interleaved with P1 misses. DONE with `winner`=0; Ack → I; next Start clears scores.
- **Gravity, `WWM_GRAVITY_EN`, GRAV_PERIOD=1:** `y_init`=400, `vy`=4. `proj_y` sequence 396, 393, 391, 390, 390, 391.
- **Reset mid-FLIGHT and Fire during FLIGHT:** Fire in FLIGHT leaves `vx`/`vy` unchanged. Reset mid-flight drops all outputs to reset values on the same cycle.
